// File: rtl/div_seq.sv
// Sequential radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Stalls the E stage while iterating and pulses ValidE with the result.
module div_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            StartE,
    input  logic            FlushE,
    input  logic [1:0]      funct3E,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    output logic            StallE,
    output logic            ValidE,
    output logic [XLEN-1:0] ResultE
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic            sel_rem;
    logic            neg_q;
    logic            neg_r;
    logic [XLEN-1:0] dvd;
    logic [XLEN-1:0] dvs;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;

    logic            is_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic            div_zero;
    logic            ovf;
    logic            accept;
    logic            last;
    logic [XLEN:0]   sh;
    logic [XLEN:0]   diff;
    logic            take;
    logic [XLEN-1:0] rem_nx;
    logic [XLEN-1:0] res;

    // Operand conditioning and special-case detection for the accept cycle
    always_comb begin
        is_signed = ~funct3E[0];
        a_neg     = is_signed & SrcAE[XLEN-1];
        b_neg     = is_signed & SrcBE[XLEN-1];
        a_abs     = a_neg ? (~SrcAE + 1'b1) : SrcAE;
        b_abs     = b_neg ? (~SrcBE + 1'b1) : SrcBE;
        div_zero  = (SrcBE == '0);
        ovf       = is_signed
                  & (SrcAE == {1'b1, {(XLEN-1){1'b0}}})
                  & (SrcBE == '1);
        accept    = (state == IDLE) & StartE & ~FlushE;
        last      = (cnt == CW'(XLEN-1));
    end

    // One restoring step; the partial remainder is kept one bit wider
    // during compare so divisors above 2^(XLEN-1) still work
    always_comb begin
        sh     = {rem, dvd[XLEN-1]};
        diff   = sh - {1'b0, dvs};
        take   = ~diff[XLEN];
        rem_nx = take ? diff[XLEN-1:0] : sh[XLEN-1:0];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, stall request and valid pulse; flush always wins
    always_comb begin
        state_nx = state;
        StallE   = 1'b0;
        ValidE   = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    StallE   = 1'b1;
                    state_nx = (div_zero | ovf) ? DONE : CALC;
                end
            end
            CALC: begin
                StallE = 1'b1;
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                ValidE   = ~FlushE;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (FlushE) begin
            state_nx = IDLE;
        end
    end

    // Operand latch on accept; special cases preload the final answer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            sel_rem <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            dvd     <= '0;
            dvs     <= '0;
            rem     <= '0;
            quo     <= '0;
        end else if (accept) begin
            cnt     <= '0;
            sel_rem <= funct3E[1];
            if (div_zero) begin
                quo   <= '1;
                rem   <= SrcAE;
                neg_q <= 1'b0;
                neg_r <= 1'b0;
                dvd   <= '0;
                dvs   <= '0;
            end else if (ovf) begin
                quo   <= {1'b1, {(XLEN-1){1'b0}}};
                rem   <= '0;
                neg_q <= 1'b0;
                neg_r <= 1'b0;
                dvd   <= '0;
                dvs   <= '0;
            end else begin
                quo   <= '0;
                rem   <= '0;
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
                dvd   <= a_abs;
                dvs   <= b_abs;
            end
        end else if (state == CALC) begin
            rem <= rem_nx;
            dvd <= {dvd[XLEN-2:0], 1'b0};
            quo <= {quo[XLEN-2:0], take};
            cnt <= cnt + 1'b1;
        end
    end

    // Sign fix-up and output gating
    always_comb begin
        if (sel_rem) begin
            res = neg_r ? (~rem + 1'b1) : rem;
        end else begin
            res = neg_q ? (~quo + 1'b1) : quo;
        end
        ResultE = ValidE ? res : '0;
    end

    // The E stage must hold the divide while we iterate
    a_start_held: assert property (
        @(posedge clk) disable iff (!rst_n)
        (state == CALC && !FlushE) |-> StartE
    );

endmodule

// File: tb/tb_div_seq.sv
// Directed and random checks of div_seq against an arithmetic model.
// Also watches the ValidE/StallE/ResultE invariants every cycle.
module tb_div_seq;

    logic        clk;
    logic        rst_n;
    logic        StartE;
    logic        FlushE;
    logic [1:0]  funct3E;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        StallE;
    logic        ValidE;
    logic [31:0] ResultE;

    int passed = 0;
    int total  = 0;
    logic prev_valid = 1'b0;

    div_seq #(.XLEN(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .StartE  (StartE),
        .FlushE  (FlushE),
        .funct3E (funct3E),
        .SrcAE   (SrcAE),
        .SrcBE   (SrcBE),
        .StallE  (StallE),
        .ValidE  (ValidE),
        .ResultE (ResultE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ref_res(input logic [1:0] f,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        int sa;
        int sb;
        logic ov;
        sa = a;
        sb = b;
        ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            2'b00: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ov) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            2'b01: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            2'b10: begin
                if (b == 0) return a;
                if (ov) return 32'h0;
                return 32'(sa % sb);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_stalls(input logic [1:0] f,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
        if (b == 0) return 1;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Runs one op from the next cycle; checks stall count and result
    task automatic do_op(input string tag, input logic [1:0] f,
                         input logic [31:0] a, input logic [31:0] b);
        int   stalls;
        logic got;
        stalls = 0;
        got    = 1'b0;
        @(negedge clk);
        StartE  = 1'b1;
        FlushE  = 1'b0;
        funct3E = f;
        SrcAE   = a;
        SrcBE   = b;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (ValidE) begin
                chk({tag, " result"}, ResultE, ref_res(f, a, b));
                got    = 1'b1;
                StartE = 1'b0;
                break;
            end
            if (StallE) stalls++;
            if (i == 1) begin
                SrcAE   = ~a;
                SrcBE   = b + 32'd3;
                funct3E = ~f;
            end
            @(negedge clk);
        end
        StartE = 1'b0;
        chk({tag, " valid seen"}, {31'b0, got}, 32'd1);
        chk({tag, " stalls"}, stalls, ref_stalls(f, a, b));
    endtask

    // Cycle invariants
    always begin
        @(negedge clk);
        #3;
        chk("stall&valid", {31'b0, StallE & ValidE}, 32'd0);
        chk("valid twice", {31'b0, ValidE & prev_valid}, 32'd0);
        if (!ValidE) chk("result idle", ResultE, 32'd0);
        prev_valid = ValidE;
    end

    initial begin
        int nv;
        logic [1:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        int r;

        rst_n   = 1'b0;
        StartE  = 1'b0;
        FlushE  = 1'b0;
        funct3E = 2'b00;
        SrcAE   = '0;
        SrcBE   = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset stall", {31'b0, StallE}, 32'd0);
        chk("reset valid", {31'b0, ValidE}, 32'd0);
        chk("reset result", ResultE, 32'd0);
        rst_n = 1'b1;

        do_op("divu 100/7", 2'b01, 32'd100, 32'd7);
        do_op("remu 100/7", 2'b11, 32'd100, 32'd7);
        do_op("div -7/2", 2'b00, -32'sd7, 32'd2);
        do_op("rem -7/2", 2'b10, -32'sd7, 32'd2);
        do_op("div 5/0", 2'b00, 32'd5, 32'd0);
        do_op("remu 5/0", 2'b11, 32'd5, 32'd0);
        do_op("div ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("rem ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("divu big dvs", 2'b01, 32'hFFFF_FFFE, 32'h8000_0001);

        // Flush in the tenth CALC cycle
        @(negedge clk);
        StartE  = 1'b1;
        funct3E = 2'b01;
        SrcAE   = 32'd1000;
        SrcBE   = 32'd3;
        repeat (10) @(negedge clk);
        FlushE = 1'b1;
        #1;
        chk("flush calc valid", {31'b0, ValidE}, 32'd0);
        @(negedge clk);
        StartE = 1'b0;
        FlushE = 1'b0;
        #1;
        chk("flush idle stall", {31'b0, StallE}, 32'd0);
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (ValidE) nv++;
        end
        chk("flush no valid", nv, 32'd0);
        do_op("divu 9/3", 2'b01, 32'd9, 32'd3);

        // Flush landing on DONE suppresses the pulse
        @(negedge clk);
        StartE  = 1'b1;
        funct3E = 2'b00;
        SrcAE   = 32'd5;
        SrcBE   = 32'd0;
        @(negedge clk);
        StartE = 1'b0;
        FlushE = 1'b1;
        #1;
        chk("flush done valid", {31'b0, ValidE}, 32'd0);
        chk("flush done result", ResultE, 32'd0);
        @(negedge clk);
        FlushE = 1'b0;
        #1;
        chk("after flush done", {31'b0, ValidE}, 32'd0);

        // Async reset in the twentieth CALC cycle
        @(negedge clk);
        StartE  = 1'b1;
        funct3E = 2'b01;
        SrcAE   = 32'd12345;
        SrcBE   = 32'd7;
        repeat (20) @(negedge clk);
        #1;
        rst_n  = 1'b0;
        StartE = 1'b0;
        #1;
        chk("arst stall", {31'b0, StallE}, 32'd0);
        chk("arst valid", {31'b0, ValidE}, 32'd0);
        chk("arst result", ResultE, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_op("b2b divu", 2'b01, 32'hFFFF_FFFF, 32'd1);
        do_op("b2b rem", 2'b10, 32'hFFFF_FFFF, 32'd1);

        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            f = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            if (r == 0) b = 32'd0;
            if (r == 1) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            if (r == 2) b = 32'($urandom_range(1, 15));
            if (r == 3) a = 32'($urandom_range(0, 1000));
            if (r == 4) b = -32'($urandom_range(1, 15));
            do_op("random", f, a, b);
        end

        repeat (2) @(negedge clk);
        #4;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
